// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: WIDTH-bit pipeline stage with a DEPTH-entry circular buffer and valid/ready on both sides.
// Optional zero-latency pass-through when empty is enabled by defining PIPE_BYPASS_EN.
module elastic_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_active;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_store;
    logic w_bypassTake;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_active = !RST && enable && !flush;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign in_ready = w_active && !w_full;
    assign w_push   = in_valid && in_ready;
    assign count    = r_count;

`ifdef PIPE_BYPASS_EN
    logic w_bypass;
    assign w_bypass     = w_active && w_empty && in_valid;
    assign w_bypassTake = w_bypass && out_ready;
    assign out_valid    = w_active && (!w_empty || in_valid);
    assign out_data     = !w_empty ? r_buf[r_rdPtr] : (w_bypass ? in_data : '0);
`else
    assign w_bypassTake = 1'b0;
    assign out_valid    = w_active && !w_empty;
    assign out_data     = w_empty ? '0 : r_buf[r_rdPtr];
`endif

    // A bypassed item is consumed directly, so it neither occupies nor frees an entry.
    assign w_pop   = out_valid && out_ready && !w_empty;
    assign w_store = w_push && !w_bypassTake;

    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_buf[r_wrPtr] <= in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_store) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg (WIDTH=32, DEPTH=4): directed vector table, corner sequences,
// and random traffic against a queue-based reference model. PIPE_BYPASS_EN selects the bypass checks.
module tb_elastic_pipe_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef PIPE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             enable;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst, en, fl, iv, ordy;
        logic [31:0] din;
        logic        expIr, expOv;
        logic [31:0] expDout;
        int          expCnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model[$];

    elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic rst, en, fl, iv, ordy, input logic [31:0] din);
        RST = rst; enable = en; flush = fl; in_valid = iv; out_ready = ordy; in_data = din;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic addVec(input logic rst, en, fl, iv, ordy, input logic [31:0] din,
                          input logic ir, ov, input logic [31:0] dout, input int cnt);
        vecs.push_back('{rst, en, fl, iv, ordy, din, ir, ov, dout, cnt});
    endtask

    // Reference: an ideal FIFO of up to DEPTH items judged purely from the handshake rules.
    task automatic modelExpect(output logic ir, output logic ov, output logic [31:0] dout,
                               output int cnt, output logic byp);
        logic active;
        active = !RST && enable && !flush;
        ir     = active && (model.size() < DEPTH);
        byp    = BYPASS && active && (model.size() == 0) && in_valid;
        ov     = active && ((model.size() != 0) || byp);
        dout   = (model.size() != 0) ? model[0] : (byp ? in_data : 32'h0);
        cnt    = model.size();
    endtask

    task automatic modelCycle(input string tag);
        logic ir, ov, byp;
        logic [31:0] dout;
        int cnt;
        #1;
        modelExpect(ir, ov, dout, cnt, byp);
        checkOutput({tag, " in_ready"},  32'(in_ready),  32'(ir));
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        checkOutput({tag, " out_data"},  out_data,       dout);
        checkOutput({tag, " count"},     32'(count),     32'(cnt));
        @(posedge CLK);
        if (RST || flush) begin
            model.delete();
        end else if (!(byp && out_ready)) begin
            if (ov && out_ready) void'(model.pop_front());
            if (in_valid && ir) model.push_back(in_data);
        end
        @(negedge CLK);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 1, 0, 0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        model.delete();
    endtask

    initial begin
        resetCycle();

`ifndef PIPE_BYPASS_EN
        // Reset then stream
        addVec(1,1,0,0,0,0,        0,0,0,0);
        addVec(1,1,0,0,0,0,        0,0,0,0);
        addVec(0,1,0,1,1,'h11,     1,0,0,0);
        addVec(0,1,0,1,1,'h22,     1,1,'h11,1);
        addVec(0,1,0,1,1,'h33,     1,1,'h22,1);
        addVec(0,1,0,0,1,0,        1,1,'h33,1);
        addVec(0,1,0,0,1,0,        1,0,0,0);
        // Fill and backpressure
        addVec(0,1,0,1,0,'hA0,     1,0,0,0);
        addVec(0,1,0,1,0,'hA1,     1,1,'hA0,1);
        addVec(0,1,0,1,0,'hA2,     1,1,'hA0,2);
        addVec(0,1,0,1,0,'hA3,     1,1,'hA0,3);
        addVec(0,1,0,1,0,'hA4,     0,1,'hA0,4);
        addVec(0,1,0,0,1,0,        0,1,'hA0,4);
        addVec(0,1,0,0,1,0,        1,1,'hA1,3);
        addVec(0,1,0,0,1,0,        1,1,'hA2,2);
        addVec(0,1,0,0,1,0,        1,1,'hA3,1);
        addVec(0,1,0,0,1,0,        1,0,0,0);
        // Simultaneous push/pop at count 2, wrapping the pointers
        addVec(0,1,0,1,0,'hB0,     1,0,0,0);
        addVec(0,1,0,1,0,'hB1,     1,1,'hB0,1);
        addVec(0,1,0,1,1,'hB2,     1,1,'hB0,2);
        addVec(0,1,0,1,1,'hB3,     1,1,'hB1,2);
        addVec(0,1,0,1,1,'hB4,     1,1,'hB2,2);
        addVec(0,1,0,1,1,'hB5,     1,1,'hB3,2);
        addVec(0,1,0,1,1,'hB6,     1,1,'hB4,2);
        addVec(0,1,0,1,1,'hB7,     1,1,'hB5,2);
        addVec(0,1,0,0,1,0,        1,1,'hB6,2);
        addVec(0,1,0,0,1,0,        1,1,'hB7,1);
        addVec(0,1,0,0,1,0,        1,0,0,0);
        // Stall then flush with a dropped input
        addVec(0,1,0,1,0,'h01,     1,0,0,0);
        addVec(0,1,0,1,0,'h02,     1,1,'h01,1);
        addVec(0,1,0,1,0,'h03,     1,1,'h01,2);
        addVec(0,0,0,1,1,'h99,     0,0,'h01,3);
        addVec(0,0,0,1,1,'h99,     0,0,'h01,3);
        addVec(0,0,0,1,1,'h99,     0,0,'h01,3);
        addVec(0,1,1,1,1,'hC0,     0,0,'h01,3);
        addVec(0,1,0,0,0,0,        1,0,0,0);
        // Reset mid-stream
        addVec(0,1,0,1,0,'hE0,     1,0,0,0);
        addVec(0,1,0,1,0,'hE1,     1,1,'hE0,1);
        addVec(1,1,0,1,0,'hE2,     0,0,'hE0,2);
        addVec(0,1,0,1,1,'hE3,     1,0,0,0);
        addVec(0,1,0,0,1,0,        1,1,'hE3,1);
        addVec(0,1,0,0,1,0,        1,0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].din);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].expIr));
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expOv));
            checkOutput($sformatf("vec%0d out_data", i),  out_data,       vecs[i].expDout);
            checkOutput($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].expCnt));
            @(posedge CLK);
            @(negedge CLK);
        end

        // Push and pop together at DEPTH-1 keeps the occupancy steady
        resetCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 1, 0, 32'hF0 + 32'(k));
            modelCycle("fill3");
        end
        applyStimulus(0, 1, 0, 1, 1, 32'hF3);
        #1;
        checkOutput("cnt3 pushpop in_ready", 32'(in_ready), 32'h1);
        checkOutput("cnt3 pushpop count", 32'(count), 32'h3);
        @(posedge CLK);
        @(negedge CLK);
        applyStimulus(0, 1, 0, 0, 0, 0);
        #1;
        checkOutput("cnt3 after count", 32'(count), 32'h3);
        checkOutput("cnt3 after out_data", out_data, 32'hF1);
        @(posedge CLK);
        @(negedge CLK);
`else
        // Zero-latency pass-through, then a stored push when downstream stalls
        applyStimulus(0, 1, 0, 1, 1, 32'hD0);
        #1;
        checkOutput("bypass out_valid", 32'(out_valid), 32'h1);
        checkOutput("bypass out_data", out_data, 32'hD0);
        checkOutput("bypass count", 32'(count), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        applyStimulus(0, 1, 0, 0, 1, 0);
        #1;
        checkOutput("bypass after count", 32'(count), 32'h0);
        checkOutput("bypass after out_valid", 32'(out_valid), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        applyStimulus(0, 1, 0, 1, 0, 32'hD1);
        #1;
        checkOutput("bypass held out_data", out_data, 32'hD1);
        @(posedge CLK);
        @(negedge CLK);
        applyStimulus(0, 1, 0, 0, 0, 0);
        #1;
        checkOutput("bypass stored count", 32'(count), 32'h1);
        checkOutput("bypass stored out_data", out_data, 32'hD1);
        @(posedge CLK);
        @(negedge CLK);
`endif

        // Random traffic with alternating backpressure phases
        resetCycle();
        for (int c = 0; c < 600; c++) begin
            logic ordy;
            ordy = ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
                          $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), ordy, $urandom);
            modelCycle($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
